// File: rtl/onewire_slave_phy.sv
// 1-Wire slave bit/byte engine: reset/presence handling and LSB-first
// byte receive/transmit over an open-drain bus.
module onewire_slave_phy #(
    parameter int RESET_MIN_CYC = 4800,
    parameter int PRES_WAIT_CYC = 300,
    parameter int PRES_LEN_CYC  = 1200,
    parameter int SAMPLE_CYC    = 300,
    parameter int HOLD0_CYC     = 300
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        onewire_bus,
    input  logic       direction,
    input  logic [7:0] in_byte,
    input  logic       next_strobe,
    output logic [7:0] out_byte,
    output logic       finished,
    output logic       bus_reset,
    output logic       tx_underrun
);

    localparam int M1 = (RESET_MIN_CYC > PRES_LEN_CYC) ? RESET_MIN_CYC : PRES_LEN_CYC;
    localparam int M2 = (PRES_WAIT_CYC > SAMPLE_CYC) ? PRES_WAIT_CYC : SAMPLE_CYC;
    localparam int M3 = (M2 > HOLD0_CYC) ? M2 : HOLD0_CYC;
    localparam int MAXP = (M1 > M3) ? M1 : M3;
    localparam int CW = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] T_RMIN   = CW'(RESET_MIN_CYC);
    localparam logic [CW-1:0] T_PWAIT  = CW'(PRES_WAIT_CYC - 1);
    localparam logic [CW-1:0] T_PLEN   = CW'(PRES_LEN_CYC - 1);
    localparam logic [CW-1:0] T_SAMPLE = CW'(SAMPLE_CYC - 1);
    localparam logic [CW-1:0] T_HOLD0  = CW'(HOLD0_CYC - 1);
    localparam logic [CW-1:0] T_MAX    = '1;

    typedef enum logic [2:0] {
        IDLE,
        SLOT_RX,
        SLOT_TX0,
        SLOT_END,
        RST_LOW,
        PRES_WAIT,
        PRES_DRIVE
    } state_t;

    state_t state, state_nxt;

    logic [2:0]    sync;
    logic          bus_s;
    logic          fall;
    logic [CW-1:0] low_cnt;
    logic [CW-1:0] tmr;
    logic [2:0]    bit_cnt;
    logic [7:0]    rx_sh;
    logic [7:0]    tx_sh;
    logic          tx_valid;
    logic          dir_lat;

    logic dir_now;
    logic underrun;
    logic tx_bit;
    logic rst_hit;
    logic byte_done;
    logic in_flight;
    logic strobe_ok;
    logic drive_low;
    logic fin_nxt;
    logic br_nxt;
    logic ur_nxt;

    assign bus_s = sync[1];
    assign fall  = sync[2] & ~sync[1];

    // Direction is only sampled at the first bit of a byte
    assign dir_now   = (bit_cnt == 3'd0) ? direction : dir_lat;
    assign underrun  = dir_now && (bit_cnt == 3'd0) && !tx_valid;
    assign tx_bit    = underrun ? 1'b1 : tx_sh[0];
    assign rst_hit   = (low_cnt == T_RMIN) && (state != RST_LOW);
    assign byte_done = (state == SLOT_END) && bus_s && (bit_cnt == 3'd7);

    assign in_flight = (dir_lat && (bit_cnt != 3'd0 || state == SLOT_TX0
                        || state == SLOT_END))
                     || (state == IDLE && fall && bit_cnt == 3'd0);
    assign strobe_ok = next_strobe && direction && !in_flight;

    assign onewire_bus = drive_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    if (!dir_now) state_nxt = SLOT_RX;
                    else if (tx_bit) state_nxt = SLOT_END;
                    else state_nxt = SLOT_TX0;
                end
            end
            SLOT_RX:    if (tmr == T_SAMPLE) state_nxt = SLOT_END;
            SLOT_TX0:   if (tmr == T_HOLD0) state_nxt = SLOT_END;
            SLOT_END:   if (bus_s) state_nxt = IDLE;
            RST_LOW:    if (bus_s) state_nxt = PRES_WAIT;
            PRES_WAIT:  if (tmr == T_PWAIT) state_nxt = PRES_DRIVE;
            PRES_DRIVE: if (tmr == T_PLEN) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
        if (rst_hit) state_nxt = RST_LOW;
    end

    always_comb begin
        drive_low = (state == SLOT_TX0) || (state == PRES_DRIVE);
        fin_nxt   = byte_done && !rst_hit;
        br_nxt    = (state == PRES_DRIVE) && (tmr == T_PLEN) && !rst_hit;
        ur_nxt    = (state == IDLE) && fall && underrun && !rst_hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync        <= 3'b111;
            low_cnt     <= '0;
            tmr         <= '0;
            bit_cnt     <= 3'd0;
            rx_sh       <= 8'h00;
            tx_sh       <= 8'h00;
            tx_valid    <= 1'b0;
            dir_lat     <= 1'b0;
            out_byte    <= 8'h00;
            finished    <= 1'b0;
            bus_reset   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            sync        <= {sync[1:0], onewire_bus};
            finished    <= fin_nxt;
            bus_reset   <= br_nxt;
            tx_underrun <= ur_nxt;

            // Our own drive never counts toward a master reset
            if (drive_low || bus_s) low_cnt <= '0;
            else if (low_cnt != T_RMIN) low_cnt <= low_cnt + 1'b1;

            if (state_nxt != state) tmr <= '0;
            else if (tmr != T_MAX) tmr <= tmr + 1'b1;

            if (rst_hit) begin
                bit_cnt  <= 3'd0;
                tx_valid <= 1'b0;
            end else begin
                if (state == IDLE && fall) begin
                    dir_lat <= dir_now;
                    if (underrun) tx_sh <= 8'hFF;
                end
                if (state == SLOT_RX && tmr == T_SAMPLE) begin
                    rx_sh <= {bus_s, rx_sh[7:1]};
                end
                if (state == SLOT_END && bus_s) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (dir_lat) tx_sh <= {1'b1, tx_sh[7:1]};
                    if (bit_cnt == 3'd7) begin
                        if (!dir_lat) out_byte <= rx_sh;
                        else tx_valid <= 1'b0;
                    end
                end
                // A load in the finished cycle beats the end-of-byte clear
                if (strobe_ok) begin
                    tx_sh    <= in_byte;
                    tx_valid <= 1'b1;
                end
            end
        end
    end

endmodule
